sig_detection: RTL and testbench



---
 rtl/sig_detection.sv | 58 +++++
 tb/tb_sig_detection.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sig_detection.sv
// Rising-edge triggered gate generator: each 0->1 transition of B opens a
// gate on OUT lasting `duration` clock cycles, retriggerable.
module sig_detection #(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             B,
    input  logic [CNT_W-1:0] duration,
    output logic             OUT
);

    logic             b_s;
    logic             b_d;
    logic             rise;
    logic [CNT_W-1:0] counter;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign b_s = B;
        end else begin : g_sync
            logic sync_reg [SYNC_STAGES];
            for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sync_reg[gi] <= 1'b0;
                    end else if (gi == 0) begin
                        sync_reg[gi] <= B;
                    end else begin
                        sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
                    end
                end
            end
            assign b_s = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    assign rise = b_s & ~b_d;

    // b_d resets high so a B already asserted at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_d     <= 1'b1;
            counter <= '0;
        end else begin
            b_d <= b_s;
            if (rise) begin
                counter <= duration;
            end else if (counter != '0) begin
                counter <= counter - 1'b1;
            end
        end
    end

    assign OUT = (counter != '0);

endmodule

// File: tb/tb_sig_detection.sv
// Scoreboard bench for sig_detection: a behavioural model pushes the expected
// counter value per driven cycle, which is popped and compared after the edge.
module tb_sig_detection;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             B;
    logic [CNT_W-1:0] duration;
    logic             OUT;

    int n_checks = 0;
    int n_fail   = 0;

    logic [CNT_W-1:0] exp_q [$];
    logic [CNT_W-1:0] m_cnt;
    logic             m_bd;
    int               cyc = 0;

    sig_detection #(.CNT_W(CNT_W), .SYNC_STAGES(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .B        (B),
        .duration (duration),
        .OUT      (OUT)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives one cycle, returns at the following negedge.
    task automatic drive_cycle(input logic b, input logic [CNT_W-1:0] dur);
        logic [CNT_W-1:0] e;
        B        = b;
        duration = dur;
        if (b && !m_bd)       m_cnt = dur;
        else if (m_cnt != 0)  m_cnt = m_cnt - 1'b1;
        m_bd = b;
        exp_q.push_back(m_cnt);
        @(posedge clk);
        #1;
        cyc++;
        e = exp_q.pop_front();
        check($sformatf("out@%0d", cyc), int'(OUT), int'(e != 0));
        check($sformatf("cnt@%0d", cyc), int'(dut.counter), int'(e));
        $display("cycle %0d B=%0b dur=%0d OUT=%0b counter=%0d exp=%0d",
                 cyc, b, dur, OUT, dut.counter, e);
        @(negedge clk);
    endtask

    task automatic run(input logic b, input logic [CNT_W-1:0] dur, input int n);
        for (int i = 0; i < n; i++) drive_cycle(b, dur);
    endtask

    initial begin
        rst_n    = 1'b0;
        B        = 1'b0;
        duration = '0;
        m_cnt    = '0;
        m_bd     = 1'b1;
        #1;
        check("reset_out", int'(OUT), 0);
        check("reset_cnt", int'(dut.counter), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single pulse, duration 3
        run(0, 3, 1);
        run(1, 3, 1);
        run(0, 3, 5);
        // long B level: single trigger
        run(1, 3, 5);
        run(0, 3, 3);
        // duration change mid-gate is ignored
        run(1, 5, 1);
        run(0, 2, 7);
        // retrigger after 3 cycles
        run(1, 6, 1);
        run(0, 6, 2);
        run(1, 6, 1);
        run(0, 6, 8);
        // cancel with duration 0, then idle zero-duration rise
        run(1, 6, 1);
        run(0, 6, 2);
        run(1, 0, 1);
        run(0, 0, 2);
        run(1, 0, 1);
        run(0, 0, 3);
        // asynchronous reset mid-gate
        run(1, 7, 1);
        run(0, 7, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", int'(OUT), 0);
        check("async_rst_cnt", int'(dut.counter), 0);
        m_cnt = '0;
        m_bd  = 1'b1;
        B     = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        // B high across release: no gate until a fresh rise
        run(1, 4, 3);
        run(0, 4, 1);
        run(1, 2, 1);
        run(0, 2, 4);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
